host_ctrl_decoder: RTL and testbench

//  Receive end of the host interface at the TCAD top. Takes the packed host_controller word and ex_bus.

---
 rtl/host_ctrl_decoder_pkg.sv | 28 ++
 rtl/host_ctrl_decoder_run_sequencer.sv | 84 ++++++++
 rtl/host_ctrl_decoder.sv | 140 ++++++++++++++
 tb/tb_host_ctrl_decoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/host_ctrl_decoder_pkg.sv
// Shared field layout, widths and FSM encoding for the host control decoder.
package host_ctrl_decoder_pkg;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int PE_INST  = 48;
    localparam int SPM_INST = 24;
    localparam int A_W      = 16;

    localparam int H_C_W = PE_INST + COLS + 1 + ROWS + 2;
    localparam int EX_W  = 2 + A_W + 32;

    localparam int HC_PE_LSB  = PE_INST;
    localparam int HC_LSU_BIT = HC_PE_LSB + COLS;
    localparam int HC_ROW_LSB = HC_LSU_BIT + 1;
    localparam int HC_SPM_BIT = HC_ROW_LSB + ROWS;
    localparam int HC_RUN_BIT = HC_SPM_BIT + 1;

    localparam int EX_ADDR_LSB = 32;
    localparam int EX_REN_BIT  = EX_ADDR_LSB + A_W;
    localparam int EX_WEN_BIT  = EX_REN_BIT + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } run_state_e;

endpackage

// File: rtl/host_ctrl_decoder_run_sequencer.sv
// Run request edge detect, iteration counter and pending-run queue.
module host_ctrl_decoder_run_sequencer
    import host_ctrl_decoder_pkg::*;
#(
    parameter int RUN_CYCLES = 32,
    parameter int PEND_MAX   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_run_start,
    output logic o_busy,
    output logic o_iter_done
);

    localparam int CW = $clog2(RUN_CYCLES);
    localparam int PW = $clog2(PEND_MAX + 1);
    localparam logic [CW-1:0] C_LAST = CW'(RUN_CYCLES - 1);
    localparam logic [PW-1:0] P_MAX  = PW'(PEND_MAX);

    run_state_e    r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [PW-1:0] r_pend, w_pend_nxt;
    logic          r_run_q, r_start, w_start_nxt;
    logic          w_edge, w_done;

    assign w_edge = i_run & ~r_run_q;
    assign w_done = (r_state == S_RUN) && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_run_q <= 1'b0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
            r_run_q <= i_run;
            r_start <= w_start_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_start_nxt = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_edge) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = C_LAST;
                    w_start_nxt = 1'b1;
                end
            end
            S_RUN: begin
                if (w_done) begin
                    if (r_pend != '0 || w_edge) begin
                        w_cnt_nxt   = C_LAST;
                        w_start_nxt = 1'b1;
                        if (!w_edge)
                            w_pend_nxt = r_pend - 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    // Requests beyond the queue depth are lost.
                    if (w_edge && r_pend < P_MAX)
                        w_pend_nxt = r_pend + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_run_start = r_start;
    assign o_busy      = (r_state == S_RUN);
    assign o_iter_done = w_done;

endmodule

// File: rtl/host_ctrl_decoder.sv
// Host control word / ex_bus receive decoder for the TCAD top.
// Optional HC_ERR_CHECK_EN enables the sticky hc_err protocol checker.
module host_ctrl_decoder
    import host_ctrl_decoder_pkg::*;
#(
    parameter int RUN_CYCLES = 32,
    parameter int PEND_MAX   = 3,
    parameter int SPM_RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [H_C_W-1:0]     host_controller,
    input  logic [EX_W-1:0]      ex_bus,
    output logic [ROWS*COLS-1:0] pe_cfg_we,
    output logic [ROWS-1:0]      lsu_cfg_we,
    output logic [PE_INST-1:0]   cfg_inst,
    output logic                 spm_cfg_we,
    output logic [SPM_INST-1:0]  spm_cfg,
    output logic                 run_start,
    output logic                 busy,
    output logic                 iter_done,
    output logic                 spm_wen,
    output logic                 spm_ren,
    output logic [A_W-1:0]       spm_addr,
    output logic [31:0]          spm_wdata,
    input  logic [31:0]          spm_rdata,
    output logic [31:0]          ex_rdata,
    output logic                 ex_rvalid,
    output logic                 hc_err
);

    logic                 w_run, w_spm, w_lsu, w_busy, w_cfg_ok;
    logic [ROWS-1:0]      w_row_f, w_row;
    logic [COLS-1:0]      w_pe_f, w_pe;
    logic [ROWS*COLS-1:0] w_pe_we;
    logic [ROWS-1:0]      w_lsu_we;
    logic                 w_ex_wen, w_ex_ren;

    logic [ROWS*COLS-1:0] r_pe_we;
    logic [ROWS-1:0]      r_lsu_we;
    logic [PE_INST-1:0]   r_inst;
    logic                 r_spm_we;
    logic                 r_wen, r_ren;
    logic [A_W-1:0]       r_addr;
    logic [31:0]          r_wdata;
    logic [SPM_RD_LAT-1:0] r_rv;

    assign w_run    = host_controller[HC_RUN_BIT];
    assign w_spm    = host_controller[HC_SPM_BIT];
    assign w_lsu    = host_controller[HC_LSU_BIT];
    assign w_row_f  = host_controller[HC_ROW_LSB +: ROWS];
    assign w_pe_f   = host_controller[HC_PE_LSB +: COLS];
    assign w_ex_wen = ex_bus[EX_WEN_BIT];
    assign w_ex_ren = ex_bus[EX_REN_BIT];
    assign w_cfg_ok = ~w_busy & ~w_spm;

    // Row/PE fields are listed [0:N-1], so index 0 is the field MSB.
    always_comb begin
        w_row    = '0;
        w_pe     = '0;
        w_pe_we  = '0;
        w_lsu_we = '0;
        for (int r = 0; r < ROWS; r++)
            w_row[r] = w_row_f[ROWS-1-r];
        for (int c = 0; c < COLS; c++)
            w_pe[c] = w_pe_f[COLS-1-c];
        for (int r = 0; r < ROWS; r++) begin
            w_lsu_we[r] = w_row[r] & w_lsu & w_cfg_ok;
            for (int c = 0; c < COLS; c++)
                w_pe_we[r*COLS+c] = w_row[r] & w_pe[c] & w_cfg_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pe_we  <= '0;
            r_lsu_we <= '0;
            r_inst   <= '0;
            r_spm_we <= 1'b0;
            r_wen    <= 1'b0;
            r_ren    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rv     <= '0;
        end else begin
            r_pe_we  <= w_pe_we;
            r_lsu_we <= w_lsu_we;
            r_inst   <= host_controller[PE_INST-1:0];
            r_spm_we <= w_spm & ~w_busy;
            r_wen    <= w_ex_wen;
            r_ren    <= w_ex_ren & ~w_ex_wen;
            r_addr   <= ex_bus[EX_ADDR_LSB +: A_W];
            r_wdata  <= ex_bus[31:0];
            r_rv[0]  <= r_ren;
            for (int i = 1; i < SPM_RD_LAT; i++)
                r_rv[i] <= r_rv[i-1];
        end
    end

    host_ctrl_decoder_run_sequencer #(
        .RUN_CYCLES (RUN_CYCLES),
        .PEND_MAX   (PEND_MAX)
    ) u_seq (
        .clk         (clk),
        .rst         (rst),
        .i_run       (w_run),
        .o_run_start (run_start),
        .o_busy      (w_busy),
        .o_iter_done (iter_done)
    );

`ifdef HC_ERR_CHECK_EN
    logic r_err, w_err_evt;
    assign w_err_evt = (w_busy & (w_spm | (|w_row_f)))
                     | (w_spm & (|w_row_f))
                     | ((|w_row_f) & ~(|w_pe_f) & ~w_lsu)
                     | (w_ex_wen & w_ex_ren);
    always_ff @(posedge clk) begin
        if (!rst) r_err <= 1'b0;
        else      r_err <= r_err | w_err_evt;
    end
    assign hc_err = r_err;
`else
    assign hc_err = 1'b0;
`endif

    assign busy       = w_busy;
    assign pe_cfg_we  = r_pe_we;
    assign lsu_cfg_we = r_lsu_we;
    assign cfg_inst   = r_inst;
    assign spm_cfg_we = r_spm_we;
    assign spm_cfg    = r_inst[SPM_INST-1:0];
    assign spm_wen    = r_wen;
    assign spm_ren    = r_ren;
    assign spm_addr   = r_addr;
    assign spm_wdata  = r_wdata;
    assign ex_rvalid  = r_rv[SPM_RD_LAT-1];
    assign ex_rdata   = ex_rvalid ? spm_rdata : 32'h0;

endmodule

// File: tb/tb_host_ctrl_decoder.sv
// Directed self-checking bench for host_ctrl_decoder.
module tb_host_ctrl_decoder;
    import host_ctrl_decoder_pkg::*;

    logic                 clk;
    logic                 rst;
    logic [H_C_W-1:0]     host_controller;
    logic [EX_W-1:0]      ex_bus;
    logic [ROWS*COLS-1:0] pe_cfg_we;
    logic [ROWS-1:0]      lsu_cfg_we;
    logic [PE_INST-1:0]   cfg_inst;
    logic                 spm_cfg_we;
    logic [SPM_INST-1:0]  spm_cfg;
    logic                 run_start, busy, iter_done;
    logic                 spm_wen, spm_ren;
    logic [A_W-1:0]       spm_addr;
    logic [31:0]          spm_wdata, spm_rdata, ex_rdata;
    logic                 ex_rvalid, hc_err;

    logic [31:0] mem [0:255];
    logic [31:0] spm_q;
    logic        force_ones;

    int n_chk = 0;
    int n_err = 0;

    host_ctrl_decoder #(
        .RUN_CYCLES (32),
        .PEND_MAX   (3),
        .SPM_RD_LAT (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .host_controller (host_controller),
        .ex_bus          (ex_bus),
        .pe_cfg_we       (pe_cfg_we),
        .lsu_cfg_we      (lsu_cfg_we),
        .cfg_inst        (cfg_inst),
        .spm_cfg_we      (spm_cfg_we),
        .spm_cfg         (spm_cfg),
        .run_start       (run_start),
        .busy            (busy),
        .iter_done       (iter_done),
        .spm_wen         (spm_wen),
        .spm_ren         (spm_ren),
        .spm_addr        (spm_addr),
        .spm_wdata       (spm_wdata),
        .spm_rdata       (spm_rdata),
        .ex_rdata        (ex_rdata),
        .ex_rvalid       (ex_rvalid),
        .hc_err          (hc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SPM model with one cycle read latency.
    always @(posedge clk) begin
        if (spm_wen) mem[spm_addr[7:0]] <= spm_wdata;
        if (spm_ren) spm_q <= mem[spm_addr[7:0]];
    end
    assign spm_rdata = force_ones ? 32'hFFFF_FFFF : spm_q;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [H_C_W-1:0] hc(
        input logic run, input logic spm, input logic [3:0] row,
        input logic lsu, input logic [3:0] pe, input logic [47:0] inst);
        return {run, spm, row, lsu, pe, inst};
    endfunction

    function automatic logic [EX_W-1:0] ex(
        input logic wen, input logic ren, input logic [15:0] a,
        input logic [31:0] d);
        return {wen, ren, a, d};
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_strb"}, {pe_cfg_we, lsu_cfg_we, spm_cfg_we, run_start,
              busy, iter_done, spm_wen, spm_ren, ex_rvalid, hc_err}, 64'h0);
        check({tag, "_inst"}, cfg_inst, 64'h0);
        check({tag, "_scfg"}, spm_cfg, 64'h0);
        check({tag, "_bus"}, {spm_addr, spm_wdata}, 64'h0);
        check({tag, "_rd"}, ex_rdata, 64'h0);
    endtask

    logic        exp_err;
    int          n_start, n_done;
    logic        drop_seen;

    initial begin
        `ifdef HC_ERR_CHECK_EN
        exp_err = 1'b1;
        `else
        exp_err = 1'b0;
        `endif
        spm_q = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        // 1. reset with all inputs high
        rst = 1'b0;
        force_ones = 1'b1;
        host_controller = '1;
        ex_bus = '1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_zero("rst");
        end
        rst = 1'b1;
        force_ones = 1'b0;
        host_controller = '0;
        ex_bus = '0;
        check_zero("rel0");
        tick();
        check_zero("rel1");

        // 2. single PE strobe, level based, 1-cycle lag
        host_controller = hc(0, 0, 4'b1000, 0, 4'b0100, 48'h00000700002f);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("pe_lvl", pe_cfg_we, 64'h0002);
            check("inst_lvl", cfg_inst, 64'h00000700002f);
        end
        host_controller = '0;
        tick();
        check("pe_off", pe_cfg_we, 64'h0);

        // broadcast rows 2,3 x PEs 0,3 plus LSU
        host_controller = hc(0, 0, 4'b0011, 1, 4'b1001, 48'h123456789abc);
        tick();
        check("pe_bcast", pe_cfg_we, 64'h9900);
        check("lsu_bcast", lsu_cfg_we, 64'hc);
        check("err_clean", hc_err, 64'h0);

        // 3. SPM wins over PE/LSU
        host_controller = hc(0, 1, 4'b0100, 1, 4'b1111, 48'hfedcba987654);
        tick();
        check("spm_we", spm_cfg_we, 64'h1);
        check("spm_cfg", spm_cfg, 64'h987654);
        check("spm_pe0", {pe_cfg_we, lsu_cfg_we}, 64'h0);
        host_controller = '0;
        tick();
        check("spm_err", hc_err, {63'h0, exp_err});
        check("spm_off", spm_cfg_we, 64'h0);

        // 4. two pulses, second queued
        for (int t = 0; t <= 70; t++) begin
            host_controller = hc((t == 0 || t == 4), 0, 0, 0, 0, 0);
            tick();
            check($sformatf("start_c%0d", t + 1), run_start,
                  {63'h0, (t + 1 == 1) || (t + 1 == 33)});
            check($sformatf("done_c%0d", t + 1), iter_done,
                  {63'h0, (t + 1 == 32) || (t + 1 == 64)});
            check($sformatf("busy_c%0d", t + 1), busy,
                  {63'h0, (t + 1 >= 1) && (t + 1 <= 64)});
        end

        // 5. five extra pulses saturate the queue; config in RUN dropped
        n_start = 0;
        n_done = 0;
        drop_seen = 1'b0;
        for (int t = 0; t < 160; t++) begin
            host_controller = hc((t <= 10) && (t % 2 == 0), 0,
                                 (t == 20) ? 4'b1000 : 4'b0, 0,
                                 (t == 20) ? 4'b1000 : 4'b0, 0);
            tick();
            n_start += int'(run_start);
            n_done  += int'(iter_done);
            if (t == 20) drop_seen = |pe_cfg_we;
        end
        host_controller = '0;
        check("sat_start", n_start, 64'd4);
        check("sat_done", n_done, 64'd4);
        check("sat_idle", busy, 64'h0);
        check("run_drop", drop_seen, 64'h0);

        // 6. ex_bus writes then reads
        for (int i = 0; i < 100; i++) begin
            ex_bus = ex(1, 0, 16'(i), 32'(i + 1));
            tick();
            if (i == 50) check("wr_fwd", {spm_wen, spm_ren, spm_addr, spm_wdata},
                               {14'h0, 1'b1, 1'b0, 16'd50, 32'd51});
        end
        ex_bus = ex(0, 1, 16'd7, 32'h0);
        tick();
        check("rd_ren", spm_ren, 64'h1);
        check("rd_early", ex_rvalid, 64'h0);
        ex_bus = '0;
        tick();
        check("rd_valid", ex_rvalid, 64'h1);
        check("rd_data", ex_rdata, 64'd8);
        tick();
        check("rd_once", ex_rvalid, 64'h0);

        ex_bus = ex(0, 1, 16'd10, 32'h0);
        tick();
        ex_bus = ex(0, 1, 16'd11, 32'h0);
        tick();
        check("b2b_v0", {ex_rvalid, ex_rdata}, {31'h0, 1'b1, 32'd11});
        ex_bus = '0;
        tick();
        check("b2b_v1", {ex_rvalid, ex_rdata}, {31'h0, 1'b1, 32'd12});

        ex_bus = ex(1, 1, 16'd50, 32'h0000abcd);
        tick();
        check("wr_win", {spm_wen, spm_ren}, 64'h2);
        ex_bus = '0;
        tick();
        check("wr_nov", ex_rvalid, 64'h0);
        ex_bus = ex(0, 1, 16'd50, 32'h0);
        tick();
        ex_bus = '0;
        tick();
        check("wr_data", {ex_rvalid, ex_rdata}, {31'h0, 1'b1, 32'h0000abcd});
        check("err_hold", hc_err, {63'h0, exp_err});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
